weyl_stream_gen: RTL and testbench

- Multi-channel sequential Weyl bitstream generator for the stochastic-computing datapath.
- Accepts one quota per channel and builds a BITSTREAM-bit word for each channel. Word bits are set at stride-permuted positions (BASE_c + i*STRIDE) mod BITSTREAM for i < quota.
- Streams the words out one bit per channel per beat, LSB (position 0) first, under valid/ready flow control.
- A one-entry pending buffer allows back-to-back streams with no bubble.

---
 rtl/weyl_pkg.sv | 18 +
 rtl/weyl_map.sv | 24 ++
 rtl/weyl_stream_gen.sv | 153 +++++++++++++++
 tb/tb_weyl_stream_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weyl_pkg.sv
// Shared types and index helpers for the Weyl bitstream generator.
package weyl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit position of the i-th one in a stride-permuted word.
  function automatic int weyl_idx(input int base, input int i, input int stride, input int n);
    return (base + i * stride) % n;
  endfunction

  function automatic int sat_quota(input int q, input int n);
    return (q > n) ? n : q;
  endfunction

endpackage

// File: rtl/weyl_map.sv
// Combinational quota-to-word map: sets bit (BASE_C + i*STRIDE) mod N for every i below the saturated quota.
module weyl_map
  import weyl_pkg::*;
#(
  parameter int N      = 64,
  parameter int QW     = 7,
  parameter int BASE_C = 0,
  parameter int STRIDE = 17
) (
  input  logic [QW-1:0] quota,
  output logic [N-1:0]  word
);

  logic [QW-1:0] qsat;

  assign qsat = QW'(sat_quota(32'(quota), N));

  // An odd stride makes the index map a bijection, so every bit has exactly one driver.
  for (genvar i = 0; i < N; i++) begin : g_bit
    localparam int IDX = weyl_idx(BASE_C, i, STRIDE, N);
    assign word[IDX] = (QW'(i) < qsat);
  end

endmodule

// File: rtl/weyl_stream_gen.sv
// Multi-channel Weyl bitstream generator with a one-entry pending buffer and LSB-first streaming.
// Define WEYL_ONES_CNT_EN to add per-channel ones counters (ones_cnt) and a count check pulse (cnt_err).
module weyl_stream_gen
  import weyl_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int CHANNELS  = 4,
  parameter int BASE      = 61,
  parameter int STRIDE    = 17,
  parameter int CH_OFFSET = 13,
  parameter int QW        = $clog2(BITSTREAM) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*QW-1:0] in_quota,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHANNELS-1:0]    out_bits,
  output logic                   out_last
`ifdef WEYL_ONES_CNT_EN
  ,
  output logic [CHANNELS*QW-1:0] ones_cnt,
  output logic                   cnt_err
`endif
);

  localparam int N  = BITSTREAM;
  localparam int CW = $clog2(N);

  if (STRIDE % 2 == 0) begin : g_stride_chk
    $error("weyl_stream_gen: STRIDE must be odd");
  end
  if (N < 4 || (N & (N - 1)) != 0) begin : g_len_chk
    $error("weyl_stream_gen: BITSTREAM must be a power of two >= 4");
  end

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           pend_vld;
  logic [N-1:0]   pend [CHANNELS];
  logic [N-1:0]   act  [CHANNELS];
  logic [N-1:0]   word [CHANNELS];
  logic           accept, hs, last_hs, xfer;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    weyl_map #(
      .N      (N),
      .QW     (QW),
      .BASE_C (weyl_idx(BASE, c, CH_OFFSET, N)),
      .STRIDE (STRIDE)
    ) u_map (
      .quota (in_quota[c*QW +: QW]),
      .word  (word[c])
    );
    assign out_bits[c] = act[c][0];
  end

  // Valid/ready: a transfer happens on any edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.
  assign in_ready  = ~rst & ~pend_vld;
  assign out_valid = (state == RUN);
  assign out_last  = out_valid & (cnt == CW'(N - 1));
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs & out_last;
  assign xfer      = pend_vld & ((state == IDLE) | last_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_vld <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        pend[c] <= '0;
        act[c]  <= '0;
      end
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_vld <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) act[c] <= '0;
    end else begin
      // accept and xfer are exclusive: in_ready is low whenever pend is full.
      if (accept) begin
        pend_vld <= 1'b1;
        for (int c = 0; c < CHANNELS; c++) pend[c] <= word[c];
      end else if (xfer) begin
        pend_vld <= 1'b0;
      end
      if (xfer) begin
        state <= RUN;
        cnt   <= '0;
        for (int c = 0; c < CHANNELS; c++) act[c] <= pend[c];
      end else if (hs) begin
        for (int c = 0; c < CHANNELS; c++) act[c] <= act[c] >> 1;
        if (out_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef WEYL_ONES_CNT_EN
  logic [QW-1:0] ones   [CHANNELS];
  logic [QW-1:0] pend_q [CHANNELS];
  logic [QW-1:0] act_q  [CHANNELS];
  logic          mism;

  // The check includes the bit being handed over on the last beat itself.
  always_comb begin
    mism = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ones[c] + QW'(out_bits[c]) != act_q[c]) mism = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_err <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ones[c]   <= '0;
        pend_q[c] <= '0;
        act_q[c]  <= '0;
      end
    end else if (flush) begin
      cnt_err <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) ones[c] <= '0;
    end else begin
      cnt_err <= last_hs & mism;
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept) pend_q[c] <= QW'(sat_quota(32'(in_quota[c*QW +: QW]), N));
        if (xfer) begin
          ones[c]  <= '0;
          act_q[c] <= pend_q[c];
        end else if (hs) begin
          ones[c] <= ones[c] + QW'(out_bits[c]);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
    assign ones_cnt[c*QW +: QW] = ones[c];
  end
`endif

endmodule

// File: tb/tb_weyl_stream_gen.sv
// Self-checking bench for weyl_stream_gen: expected beats come from a word-level model of the quota/stride rule.
module tb_weyl_stream_gen;

  localparam int N      = 64;
  localparam int C      = 4;
  localparam int QW     = 7;
  localparam int BASE   = 61;
  localparam int STRIDE = 17;
  localparam int CHO    = 13;
  localparam int W      = C + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [C*QW-1:0] in_quota;
  logic          out_valid;
  logic          out_ready;
  logic [C-1:0]  out_bits;
  logic          out_last;
`ifdef WEYL_ONES_CNT_EN
  logic [C*QW-1:0] ones_cnt;
  logic          cnt_err;
  int            err_pulses = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  weyl_stream_gen #(
    .BITSTREAM (N),
    .CHANNELS  (C),
    .BASE      (BASE),
    .STRIDE    (STRIDE),
    .CH_OFFSET (CHO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_quota  (in_quota),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_last  (out_last)
`ifdef WEYL_ONES_CNT_EN
    ,
    .ones_cnt  (ones_cnt),
    .cnt_err   (cnt_err)
`endif
  );

`ifdef WEYL_ONES_CNT_EN
  always @(negedge clk) if (cnt_err === 1'b1) err_pulses++;
`endif

  // Reference model: build each channel's word from the quota rule, then queue 64 beats {last, bits}.
  function automatic void push_expected(input logic [C*QW-1:0] qv);
    logic [N-1:0] wd [C];
    logic [C-1:0] bits;
    int q, lim, base;
    for (int c = 0; c < C; c++) begin
      wd[c] = '0;
      q = int'(qv[c*QW +: QW]);
      lim = (q > N) ? N : q;
      base = (BASE + c * CHO) % N;
      for (int i = 0; i < lim; i++) wd[c][(base + i * STRIDE) % N] = 1'b1;
    end
    for (int b = 0; b < N; b++) begin
      for (int c = 0; c < C; c++) bits[c] = wd[c][b];
      exp_q.push_back({(b == N - 1), bits});
    end
  endfunction

  function automatic logic [C*QW-1:0] rand_vec();
    logic [C*QW-1:0] r;
    for (int c = 0; c < C; c++) r[c*QW +: QW] = QW'($urandom_range(0, 100));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_quota = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (out_bits !== '0) begin errors++; $display("FAIL reset_bits got %h want 0", out_bits); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
`ifdef WEYL_ONES_CNT_EN
    checks++; if (ones_cnt !== '0) begin errors++; $display("FAIL reset_ones_cnt got %h want 0", ones_cnt); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [C*QW-1:0] vecs [2];
    int exp_cnt [2][C] = '{'{0, 64, 64, 0}, '{1, 1, 2, 0}};
    int exp_first [2][C] = '{'{-1, 0, 0, -1}, '{61, 10, 23, -1}};
    logic [W-1:0] exp;
    vecs[0] = {7'd0, 7'd70, 7'd64, 7'd0};
    vecs[1] = {7'd0, 7'd2, 7'd1, 7'd1};
    for (int v = 0; v < 2; v++) begin
      int cnt [C];
      int first [C];
      int b;
      b = 0;
      for (int c = 0; c < C; c++) begin cnt[c] = 0; first[c] = -1; end
      @(negedge clk); in_valid = 1'b1; in_quota = vecs[v]; push_expected(vecs[v]);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_latency_early v%0d got %b want 0", v, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_latency_first v%0d got %b want 1", v, out_valid); end
      for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (out_valid === 1'b1) begin
          exp = exp_q.pop_front();
          checks++;
          if ({out_last, out_bits} !== exp) begin
            errors++; $display("FAIL dir_beat v%0d b%0d got %h want %h", v, b, {out_last, out_bits}, exp);
          end
          for (int c = 0; c < C; c++) if (out_bits[c] === 1'b1) begin cnt[c]++; if (first[c] < 0) first[c] = b; end
          b++;
        end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dir_timeout v%0d left %0d want 0", v, exp_q.size()); exp_q.delete(); end
      for (int c = 0; c < C; c++) begin
        checks++; if (cnt[c] != exp_cnt[v][c]) begin errors++; $display("FAIL dir_ones v%0d ch%0d got %0d want %0d", v, c, cnt[c], exp_cnt[v][c]); end
        checks++; if (first[c] != exp_first[v][c]) begin errors++; $display("FAIL dir_first v%0d ch%0d got %0d want %0d", v, c, first[c], exp_first[v][c]); end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_idle v%0d got %b want 0", v, out_valid); end
`ifdef WEYL_ONES_CNT_EN
      for (int c = 0; c < C; c++) begin
        checks++; if (int'(ones_cnt[c*QW +: QW]) != exp_cnt[v][c]) begin errors++; $display("FAIL dir_ones_cnt v%0d ch%0d got %0d want %0d", v, c, ones_cnt[c*QW +: QW], exp_cnt[v][c]); end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [C*QW-1:0] v1, v2;
    logic [W-1:0] exp;
    int beats;
    bit v2_sent, exp_ir;
    beats = 0; v2_sent = 1'b0;
    v1 = rand_vec(); v2 = rand_vec();
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_quota = v1; push_expected(v1);
    for (int cyc = 0; cyc < 400 && beats < 2 * N; cyc++) begin
      @(negedge clk);
      exp_ir = (cyc >= 1) && (!v2_sent || beats >= N);
      checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL b2b_in_ready cyc%0d got %b want %b", cyc, in_ready, exp_ir); end
      checks++; if (out_valid !== (cyc >= 1)) begin errors++; $display("FAIL b2b_valid cyc%0d got %b want %b", cyc, out_valid, (cyc >= 1)); end
      if (!v2_sent && in_ready === 1'b1) begin
        in_valid = 1'b1; in_quota = v2; v2_sent = 1'b1; push_expected(v2);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_last, out_bits} !== exp) begin
          errors++; $display("FAIL b2b_beat b%0d got %h want %h", beats, {out_last, out_bits}, exp);
        end
        beats++;
      end
    end
    in_valid = 1'b0;
    checks++; if (beats != 2 * N) begin errors++; $display("FAIL b2b_timeout got %0d beats want %0d", beats, 2 * N); end
    exp_q.delete();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [C*QW-1:0] v;
    logic [W-1:0] exp;
    int ones [C];
    int beats;
    beats = 0;
    for (int c = 0; c < C; c++) begin v[c*QW +: QW] = 7'd32; ones[c] = 0; end
    @(negedge clk); in_valid = 1'b1; in_quota = v; push_expected(v);
    for (int cyc = 0; cyc < 1000 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== (cyc >= 1)) begin errors++; $display("FAIL bp_valid cyc%0d got %b want %b", cyc, out_valid, (cyc >= 1)); end
      out_ready = 1'($urandom_range(0, 1));
      if (cyc >= 1) begin
        exp = exp_q[0];
        checks++;
        if ({out_last, out_bits} !== exp) begin
          errors++; $display("FAIL bp_beat b%0d got %h want %h", beats, {out_last, out_bits}, exp);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          for (int c = 0; c < C; c++) if (out_bits[c] === 1'b1) ones[c]++;
          beats++;
        end
      end
    end
    checks++; if (beats != N) begin errors++; $display("FAIL bp_timeout got %0d beats want %0d", beats, N); exp_q.delete(); end
    for (int c = 0; c < C; c++) begin
      checks++; if (ones[c] != 32) begin errors++; $display("FAIL bp_ones ch%0d got %0d want 32", c, ones[c]); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [C*QW-1:0] v1, v2, v3;
    logic [W-1:0] exp;
    int beats;
    bit v2_sent;
    beats = 0; v2_sent = 1'b0;
    v1 = rand_vec(); v2 = rand_vec(); v3 = rand_vec();
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_quota = v1; push_expected(v1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (!v2_sent && in_ready === 1'b1) begin
        in_valid = 1'b1; in_quota = v2; v2_sent = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (beats == 20) break;
        exp = exp_q.pop_front();
        checks++;
        if ({out_last, out_bits} !== exp) begin
          errors++; $display("FAIL flush_pre_beat b%0d got %h want %h", beats, {out_last, out_bits}, exp);
        end
        beats++;
      end
    end
    checks++; if (beats != 20) begin errors++; $display("FAIL flush_reach got %0d beats want 20", beats); end
    flush = 1'b1; in_valid = 1'b1; in_quota = v3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; exp_q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL flush_last got %b want 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_pend_dropped got %b want 0", out_valid); end
    in_valid = 1'b1; in_quota = v3; push_expected(v3);
    beats = 0;
    for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== (cyc >= 1)) begin errors++; $display("FAIL flush_restart_valid cyc%0d got %b want %b", cyc, out_valid, (cyc >= 1)); end
      if (out_valid === 1'b1) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_last, out_bits} !== exp) begin
          errors++; $display("FAIL flush_restart_beat b%0d got %h want %h", beats, {out_last, out_bits}, exp);
        end
        beats++;
      end
    end
    checks++; if (beats != N) begin errors++; $display("FAIL flush_restart_timeout got %0d beats want %0d", beats, N); exp_q.delete(); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [C*QW-1:0] v;
    logic [W-1:0] exp;
    int beats;
    beats = 0;
    v = rand_vec();
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_quota = v; push_expected(v);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (beats == 40) break;
        exp = exp_q.pop_front();
        checks++;
        if ({out_last, out_bits} !== exp) begin
          errors++; $display("FAIL rstmid_beat b%0d got %h want %h", beats, {out_last, out_bits}, exp);
        end
        beats++;
      end
    end
    checks++; if (beats != 40) begin errors++; $display("FAIL rstmid_reach got %0d beats want 40", beats); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (out_bits !== '0) begin errors++; $display("FAIL rstmid_bits got %h want 0", out_bits); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b want 0", out_last); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
`ifdef WEYL_ONES_CNT_EN
    checks++; if (ones_cnt !== '0) begin errors++; $display("FAIL rstmid_ones_cnt got %h want 0", ones_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid c%0d got %b want 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after_ready c%0d got %b want 1", i, in_ready); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef WEYL_ONES_CNT_EN
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL cnt_err_pulses got %0d want 0", err_pulses); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
